// File: rtl/acr_packet_generator.sv
// acr_packet_generator
//   HDMI Audio Clock Regeneration packet source. N comes from a table
//   indexed by the sample-rate code. CTS is the number of clk_pixel cycles
//   spanned by N/128 rising edges of clk_audio. It can be averaged over
//   2^AVG_LOG2 back-to-back windows. The packet is offered with a
//   valid/ready handshake, and a newer packet replaces one not yet taken.
//
//   Optional build macro: ACR_CTS_OVERRIDE_EN adds cts_override_en and
//   cts_override. When cts_override_en is high, every packet carries
//   cts_override in place of the measured CTS.
//
// Ports
//   clk_pixel       in   pixel clock, the only clock
//   reset_n         in   async active-low reset
//   clk_audio       in   asynchronous audio clock at fs (edges counted)
//   fs_sel[2:0]     in   sample-rate code (7 = reserved, treated as 48k)
//   packet_valid    out  ACR packet pending
//   packet_ready    in   scheduler accepts when valid && ready
//   header[23:0]    out  constant ACR packet header
//   sub[223:0]      out  four identical 56-bit subpackets, sub i at [56*i +: 56]
//   cts_overflow    out  sticky, CTS counter saturated
//   measuring       out  measurement window open
//   cts_override_en in   (ACR_CTS_OVERRIDE_EN only) use cts_override
//   cts_override    in   (ACR_CTS_OVERRIDE_EN only) 20-bit CTS value
module acr_packet_generator #(
  parameter int CTS_WIDTH   = 20,
  parameter int AVG_LOG2    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         clk_audio,
  input  logic [2:0]   fs_sel,
  output logic         packet_valid,
  input  logic         packet_ready,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic         cts_overflow,
  output logic         measuring
`ifdef ACR_CTS_OVERRIDE_EN
  ,
  input  logic         cts_override_en,
  input  logic [19:0]  cts_override
`endif
);

  // state   | meaning
  // IDLE    | waiting for the first audio edge at the current rate
  // MEASURE | window open, counting pixel cycles and audio edges
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam int ACC_W = CTS_WIDTH + 3;
  localparam logic [CTS_WIDTH-1:0] CTS_MAX = {CTS_WIDTH{1'b1}};
  localparam logic [2:0] WIN_LAST = 3'((1 << AVG_LOG2) - 1);

  function automatic logic [19:0] n_lookup(input logic [2:0] sel);
    logic [19:0] n;
    case (sel)
      3'd0:    n = 20'd4096;
      3'd1:    n = 20'd6272;
      3'd3:    n = 20'd12544;
      3'd4:    n = 20'd12288;
      3'd5:    n = 20'd25088;
      3'd6:    n = 20'd24576;
      default: n = 20'd6144;
    endcase
    return n;
  endfunction

  logic [SYNC_STAGES-1:0] aud_sync;
  logic                   aud_prev;
  logic                   aud_edge;

  logic [0:0]             state;
  logic [19:0]            n_active;
  logic [CTS_WIDTH-1:0]   cts_cnt;
  logic [7:0]             edge_cnt;
  logic [2:0]             win_cnt;
  logic [ACC_W-1:0]       acc;

  logic [19:0]            n_sel;
  logic [7:0]             e_active;
  logic                   rate_change;
  logic                   window_end;
  logic                   publish;
  logic [CTS_WIDTH-1:0]   measured;
  logic [ACC_W-1:0]       acc_sum;
  logic [CTS_WIDTH-1:0]   cts_avg;
  logic [19:0]            cts_pub;
  logic [55:0]            sub_word;

  // clk_audio synchroniser plus one flop for rising-edge detection
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      aud_sync <= '0;
      aud_prev <= 1'b0;
    end else begin
      aud_sync <= {aud_sync[SYNC_STAGES-2:0], clk_audio};
      aud_prev <= aud_sync[SYNC_STAGES-1];
    end
  end

  assign aud_edge = aud_sync[SYNC_STAGES-1] & ~aud_prev;

  assign n_sel       = n_lookup(fs_sel);
  assign e_active    = n_active[14:7];
  assign rate_change = (state == ST_MEASURE) && (n_sel != n_active);
  assign window_end  = (state == ST_MEASURE) && !rate_change && aud_edge &&
                       ((edge_cnt + 8'd1) == e_active);
  assign publish     = window_end && (win_cnt == WIN_LAST);

  // The ending edge cycle itself belongs to the window, hence +1; a
  // saturated counter is reported as-is rather than wrapping.
  assign measured = (cts_cnt == CTS_MAX) ? CTS_MAX : cts_cnt + 1'b1;
  assign acc_sum  = acc + ACC_W'(measured);
  assign cts_avg  = CTS_WIDTH'(acc_sum >> AVG_LOG2);

`ifdef ACR_CTS_OVERRIDE_EN
  assign cts_pub = cts_override_en ? cts_override : 20'(cts_avg);
`else
  assign cts_pub = 20'(cts_avg);
`endif

  assign sub_word = {n_active[7:0], n_active[15:8], 4'd0, n_active[19:16],
                     cts_pub[7:0], cts_pub[15:8], 4'd0, cts_pub[19:16], 8'd0};

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      n_active <= '0;
      cts_cnt  <= '0;
      edge_cnt <= '0;
      win_cnt  <= '0;
      acc      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aud_edge) begin
            state    <= ST_MEASURE;
            n_active <= n_sel;
            cts_cnt  <= '0;
            edge_cnt <= '0;
            win_cnt  <= '0;
            acc      <= '0;
          end
        end
        default: begin
          if (rate_change) begin
            state    <= ST_IDLE;
            cts_cnt  <= '0;
            edge_cnt <= '0;
            win_cnt  <= '0;
            acc      <= '0;
          end else if (window_end) begin
            // next window starts in this same cycle, so no cycle is lost
            cts_cnt  <= '0;
            edge_cnt <= '0;
            if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              acc     <= '0;
            end else begin
              win_cnt <= win_cnt + 3'd1;
              acc     <= acc_sum;
            end
          end else begin
            if (cts_cnt != CTS_MAX) cts_cnt <= cts_cnt + 1'b1;
            if (aud_edge) edge_cnt <= edge_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cts_overflow <= 1'b0;
    end else if ((state == ST_MEASURE) && (cts_cnt == CTS_MAX)) begin
      cts_overflow <= 1'b1;
    end
  end

  // publish has priority over accept: a new packet in the accept cycle stays pending
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      packet_valid <= 1'b0;
      sub          <= '0;
    end else if (publish) begin
      packet_valid <= 1'b1;
      sub          <= {4{sub_word}};
    end else if (packet_ready) begin
      packet_valid <= 1'b0;
    end
  end

  assign header    = 24'h000001;
  assign measuring = (state == ST_MEASURE);

endmodule

// File: tb/tb_acr_packet_generator.sv
module tb_acr_packet_generator;

  logic         clk_pixel = 1'b0;
  logic         reset_n   = 1'b0;
  logic         clk_audio;
  logic [2:0]   fs_a = 3'd2, fs_b = 3'd0;
  logic         ready_a = 1'b0, ready_b = 1'b0;
  logic         valid_a, valid_b;
  logic [23:0]  header_a, header_b;
  logic [223:0] sub_a, sub_b;
  logic         ovf_a, ovf_b, meas_a, meas_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int aud_base = 0;
  int aud_jit  = 0;
  int aud_cur  = 0;
  int aud_ph   = 0;
  int edge_t[$];

  logic [223:0] exp_old;

  acr_packet_generator dut_a (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .clk_audio(clk_audio),
    .fs_sel(fs_a), .packet_valid(valid_a), .packet_ready(ready_a),
    .header(header_a), .sub(sub_a), .cts_overflow(ovf_a), .measuring(meas_a)
  );

  acr_packet_generator #(.CTS_WIDTH(12), .AVG_LOG2(2)) dut_b (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .clk_audio(clk_audio),
    .fs_sel(fs_b), .packet_valid(valid_b), .packet_ready(ready_b),
    .header(header_b), .sub(sub_b), .cts_overflow(ovf_b), .measuring(meas_b)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    forever begin
      @(posedge clk_pixel);
      cyc++;
    end
  end

  // audio clock source: each rising edge is spaced aud_base + rand(0..aud_jit)
  // pixel cycles after the previous one; the time of every edge is logged
  initial begin
    clk_audio = 1'b0;
    forever begin
      @(negedge clk_pixel);
      if (aud_base == 0) begin
        clk_audio = 1'b0;
        aud_ph    = 0;
        aud_cur   = 0;
      end else begin
        if (aud_cur == 0) aud_cur = aud_base;
        aud_ph++;
        if (aud_ph >= aud_cur) begin
          clk_audio = 1'b1;
          edge_t.push_back(cyc);
          aud_ph  = 0;
          aud_cur = aud_base + int'($urandom_range(aud_jit));
        end else if (aud_ph == aud_cur / 2) begin
          clk_audio = 1'b0;
        end
      end
    end
  end

  function automatic logic [223:0] mk_sub(input int n, input int cts);
    logic [19:0] nn;
    logic [19:0] cc;
    logic [55:0] sp;
    nn = 20'(n);
    cc = 20'(cts);
    sp = {nn[7:0], nn[15:8], 4'd0, nn[19:16], cc[7:0], cc[15:8], 4'd0, cc[19:16], 8'd0};
    return {sp, sp, sp, sp};
  endfunction

  // publish k covers windows (k-1)*w .. k*w-1; edge 0 opens window 0
  function automatic int exp_cts(input int k, input int w, input int e, input int cw);
    int sum;
    int d;
    int cap;
    sum = 0;
    cap = (1 << cw) - 1;
    for (int j = (k - 1) * w; j < k * w; j++) begin
      d = edge_t[(j + 1) * e] - edge_t[j * e];
      if (d > cap) d = cap;
      sum += d;
    end
    return sum / w;
  endfunction

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n, input string tag);
    int i;
    i = 0;
    while (edge_t.size() < n && i < 60000) begin
      @(negedge clk_pixel);
      i++;
    end
    checks++;
    assert (edge_t.size() >= n) else begin
      failures++;
      $error("FAIL %s timeout observed=%0d expected=%0d", tag, edge_t.size(), n);
    end
    repeat (8) @(negedge clk_pixel);
  endtask

  // change rate 10 cycles after a fresh audio edge; the next edge opens a window
  task automatic switch_a(input logic [2:0] fs, input int base, input int jit);
    int n;
    n = edge_t.size();
    wait_edges(n + 1, "switch_sync");
    repeat (2) @(negedge clk_pixel);
    fs_a     = fs;
    aud_base = base;
    aud_jit  = jit;
    edge_t.delete();
  endtask

  task automatic accept_a();
    @(negedge clk_pixel);
    ready_a = 1'b1;
    @(negedge clk_pixel);
    ready_a = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_pixel);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_meas_a", meas_a, 0);
    chk("rst_sub_a", sub_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("header_a", header_a, 24'h000001);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_pixel);
    chk("idle_meas_a", meas_a, 0);

    // 48k, fixed 525-cycle audio period
    edge_t.delete();
    fs_a = 3'd2; aud_base = 525; aud_jit = 0;
    wait_edges(48, "s1_w1_early");
    chk("s1_no_pkt_early", valid_a, 0);
    chk("s1_meas", meas_a, 1);
    wait_edges(49, "s1_w1");
    chk("s1_valid", valid_a, 1);
    chk("s1_sub_const", sub_a, mk_sub(6144, 25200));
    chk("s1_sub_model", sub_a, mk_sub(6144, exp_cts(1, 1, 48, 20)));
    chk("s1_header", header_a, 24'h000001);

    // second window with jittered periods while the first packet is still pending
    aud_base = 50; aud_jit = 30;
    wait_edges(97, "s1_w2");
    chk("s1_hold_valid", valid_a, 1);
    chk("s1_latest_wins", sub_a, mk_sub(6144, exp_cts(2, 1, 48, 20)));
    accept_a();
    chk("s1_ready_pulse_clears", valid_a, 0);

    // 44.1k, fixed 572-cycle period
    switch_a(3'd1, 572, 0);
    repeat (3) @(negedge clk_pixel);
    chk("s2_idle_after_rate", meas_a, 0);
    wait_edges(50, "s2_w1");
    chk("s2_valid", valid_a, 1);
    chk("s2_sub_const", sub_a, mk_sub(6272, 28028));
    chk("s2_sub_model", sub_a, mk_sub(6272, exp_cts(1, 1, 49, 20)));
    accept_a();
    chk("s2_accept", valid_a, 0);

    // rate change 48k -> 96k mid-window with a packet pending
    switch_a(3'd2, 50, 30);
    wait_edges(49, "s3_w1");
    exp_old = mk_sub(6144, exp_cts(1, 1, 48, 20));
    chk("s3_valid", valid_a, 1);
    chk("s3_sub_48k", sub_a, exp_old);
    wait_edges(59, "s3_mid");
    switch_a(3'd4, 50, 30);
    repeat (3) @(negedge clk_pixel);
    chk("s3_meas_drop", meas_a, 0);
    chk("s3_pending_valid", valid_a, 1);
    chk("s3_pending_sub", sub_a, exp_old);
    wait_edges(96, "s3_w2_early");
    chk("s3_still_old", sub_a, exp_old);
    wait_edges(97, "s3_w2");
    chk("s3_valid_new", valid_a, 1);
    chk("s3_sub_96k", sub_a, mk_sub(12288, exp_cts(1, 1, 96, 20)));
    accept_a();
    chk("s3_accept", valid_a, 0);

    // asynchronous reset in the middle of a clock phase
    aud_base = 0;
    @(posedge clk_pixel);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid_a", valid_a, 0);
    chk("arst_meas_a", meas_a, 0);
    chk("arst_sub_a", sub_a, 0);
    chk("arst_ovf_b", ovf_b, 0);
    chk("arst_meas_b", meas_b, 0);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_pixel);

    // 12-bit CTS, average of four windows at 32k
    edge_t.delete();
    fs_b = 3'd0; aud_base = 40; aud_jit = 10;
    wait_edges(97, "b_w3");
    chk("b_no_pkt_before_avg", valid_b, 0);
    wait_edges(129, "b_p1");
    chk("b_valid", valid_b, 1);
    chk("b_sub_avg1", sub_b, mk_sub(4096, exp_cts(1, 4, 32, 12)));
    @(negedge clk_pixel);
    ready_b = 1'b1;
    @(negedge clk_pixel);
    ready_b = 1'b0;
    chk("b_accept", valid_b, 0);
    wait_edges(257, "b_p2");
    chk("b_sub_avg2", sub_b, mk_sub(4096, exp_cts(2, 4, 32, 12)));
    chk("b_no_ovf", ovf_b, 0);

    // audio stops: CTS counter saturates
    aud_base = 0;
    repeat (4200) @(negedge clk_pixel);
    chk("b_ovf_set", ovf_b, 1);
    chk("b_meas_on", meas_b, 1);
    repeat (100) @(negedge clk_pixel);
    chk("b_ovf_sticky", ovf_b, 1);

    @(posedge clk_pixel);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_ovf_b2", ovf_b, 0);
    chk("arst_valid_b", valid_b, 0);
    chk("arst_sub_b", sub_b, 0);
    chk("arst_meas_b2", meas_b, 0);
    chk("header_b", header_b, 24'h000001);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_pixel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
